// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Default 640x480@60 timing and derived totals for VGA timing.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Bits needed to hold 0..total-1.
    function automatic int cnt_width(input int total);
        return (total <= 2) ? 1 : $clog2(total);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_wrap_cnt.sv
`default_nettype none
// ============================================================================
// Module      : vga_wrap_cnt
// Description : Enabled up-counter that returns to 0 after reaching i_limit.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_wrap_cnt #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_limit,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_wrap
);

    logic [WIDTH-1:0] r_cnt;

    assign o_cnt  = r_cnt;
    assign o_wrap = i_en && (r_cnt == i_limit);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_wrap ? '0 : r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing
// Description : VGA raster counters, pixel request and registered sync/RGB.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic        clkin,
    input  logic        rst,
    input  logic        pix_en,
    input  logic [23:0] pix_data,
    output logic [9:0]  h_addr,
    output logic [9:0]  v_addr,
    output logic        req,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        frame_start
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_H_W     = cnt_width(c_H_TOTAL);
    localparam int c_V_W     = cnt_width(c_V_TOTAL);

    localparam logic [c_H_W-1:0] c_H_LAST     = c_H_W'(c_H_TOTAL - 1);
    localparam logic [c_H_W-1:0] c_H_ACT      = c_H_W'(H_ACTIVE);
    localparam logic [c_H_W-1:0] c_HS_FIRST   = c_H_W'(H_ACTIVE + H_FP);
    localparam logic [c_H_W-1:0] c_HS_LAST    = c_H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [c_V_W-1:0] c_V_LAST     = c_V_W'(c_V_TOTAL - 1);
    localparam logic [c_V_W-1:0] c_V_ACT      = c_V_W'(V_ACTIVE);
    localparam logic [c_V_W-1:0] c_VS_FIRST   = c_V_W'(V_ACTIVE + V_FP);
    localparam logic [c_V_W-1:0] c_VS_LAST    = c_V_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [c_H_W-1:0] w_h_cnt;
    logic [c_V_W-1:0] w_v_cnt;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic             w_hs_zone;
    logic             w_vs_zone;

    logic             r_hsync;
    logic             r_vsync;
    logic             r_blank_n;
    logic [23:0]      r_rgb;
    logic             r_origin;

    vga_wrap_cnt #(.WIDTH(c_H_W)) u_h_cnt (
        .clk     (clkin),
        .rst     (rst),
        .i_en    (pix_en),
        .i_limit (c_H_LAST),
        .o_cnt   (w_h_cnt),
        .o_wrap  (w_h_wrap)
    );

    // The horizontal wrap flag already carries pix_en.
    vga_wrap_cnt #(.WIDTH(c_V_W)) u_v_cnt (
        .clk     (clkin),
        .rst     (rst),
        .i_en    (w_h_wrap),
        .i_limit (c_V_LAST),
        .o_cnt   (w_v_cnt),
        .o_wrap  (w_v_wrap)
    );

    assign req       = (w_h_cnt < c_H_ACT) && (w_v_cnt < c_V_ACT);
    assign h_addr    = req ? 10'(w_h_cnt) : 10'd0;
    assign v_addr    = req ? 10'(w_v_cnt) : 10'd0;
    assign w_hs_zone = (w_h_cnt >= c_HS_FIRST) && (w_h_cnt <= c_HS_LAST);
    assign w_vs_zone = (w_v_cnt >= c_VS_FIRST) && (w_v_cnt <= c_VS_LAST);

    always_ff @(posedge clkin) begin
        if (rst) begin
            r_hsync   <= 1'b1;
            r_vsync   <= 1'b1;
            r_blank_n <= 1'b0;
            r_rgb     <= '0;
        end else if (pix_en) begin
            r_hsync   <= ~w_hs_zone;
            r_vsync   <= ~w_vs_zone;
            r_blank_n <= req;
            r_rgb     <= req ? pix_data : 24'd0;
        end
    end

    // Tracks "both counters are at 0" so frame_start avoids a wide compare.
    always_ff @(posedge clkin) begin
        if (rst) begin
            r_origin <= 1'b1;
        end else if (pix_en) begin
            r_origin <= w_v_wrap;
        end
    end

    assign frame_start = pix_en && !rst && r_origin;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign blank_n     = r_blank_n;
    assign vga_r       = r_rgb[23:16];
    assign vga_g       = r_rgb[15:8];
    assign vga_b       = r_rgb[7:0];

endmodule
`default_nettype wire

// File: tb/tb_vga_timing.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing
// Description : Randomised self-checking bench for vga_timing (default and
//               reduced timing instances) against a position-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing;

    int c_HA [2] = '{640, 20};
    int c_HF [2] = '{16, 3};
    int c_HS [2] = '{96, 5};
    int c_HB [2] = '{48, 4};
    int c_VA [2] = '{480, 12};
    int c_VF [2] = '{10, 2};
    int c_VS [2] = '{2, 2};
    int c_VB [2] = '{33, 3};

    logic        clkin = 1'b0;
    logic        rst;
    logic        pix_en;
    logic [23:0] pix_data;

    logic [9:0]  h_addr_o [2];
    logic [9:0]  v_addr_o [2];
    logic        req_o    [2];
    logic        hsync_o  [2];
    logic        vsync_o  [2];
    logic        blank_o  [2];
    logic [7:0]  r_o      [2];
    logic [7:0]  g_o      [2];
    logic [7:0]  b_o      [2];
    logic        fs_o     [2];

    int          pos   [2];
    logic        e_hs  [2];
    logic        e_vs  [2];
    logic        e_bn  [2];
    logic [23:0] e_rgb [2];
    int          fs_count [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clkin = ~clkin;

    vga_timing u_dut_def (
        .clkin(clkin), .rst(rst), .pix_en(pix_en), .pix_data(pix_data),
        .h_addr(h_addr_o[0]), .v_addr(v_addr_o[0]), .req(req_o[0]),
        .hsync(hsync_o[0]), .vsync(vsync_o[0]), .blank_n(blank_o[0]),
        .vga_r(r_o[0]), .vga_g(g_o[0]), .vga_b(b_o[0]), .frame_start(fs_o[0])
    );

    vga_timing #(
        .H_ACTIVE(20), .H_FP(3), .H_SYNC(5), .H_BP(4),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) u_dut_small (
        .clkin(clkin), .rst(rst), .pix_en(pix_en), .pix_data(pix_data),
        .h_addr(h_addr_o[1]), .v_addr(v_addr_o[1]), .req(req_o[1]),
        .hsync(hsync_o[1]), .vsync(vsync_o[1]), .blank_n(blank_o[1]),
        .vga_r(r_o[1]), .vga_g(g_o[1]), .vga_b(b_o[1]), .frame_start(fs_o[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int htot(input int k);
        return c_HA[k] + c_HF[k] + c_HS[k] + c_HB[k];
    endfunction

    function automatic int vtot(input int k);
        return c_VA[k] + c_VF[k] + c_VS[k] + c_VB[k];
    endfunction

    // One clkin cycle: drive, check combinational outputs, clock, check registers.
    task automatic cycle(input logic r, input logic en, input logic [23:0] dat);
        @(negedge clkin);
        rst = r; pix_en = en; pix_data = dat;
        #1;
        for (int k = 0; k < 2; k++) begin
            int h, v;
            logic act;
            h   = pos[k] % htot(k);
            v   = pos[k] / htot(k);
            act = (h < c_HA[k]) && (v < c_VA[k]);
            check($sformatf("req[%0d]", k), 32'(req_o[k]), 32'(act));
            check($sformatf("h_addr[%0d]", k), 32'(h_addr_o[k]), act ? h : 0);
            check($sformatf("v_addr[%0d]", k), 32'(v_addr_o[k]), act ? v : 0);
            check($sformatf("frame_start[%0d]", k), 32'(fs_o[k]), 32'(en && !r && pos[k] == 0));
            if (fs_o[k] === 1'b1) fs_count[k]++;
        end
        @(posedge clkin);
        #1;
        for (int k = 0; k < 2; k++) begin
            int h, v;
            logic act;
            if (r) begin
                pos[k] = 0; e_hs[k] = 1'b1; e_vs[k] = 1'b1; e_bn[k] = 1'b0; e_rgb[k] = '0;
            end else if (en) begin
                h   = pos[k] % htot(k);
                v   = pos[k] / htot(k);
                act = (h < c_HA[k]) && (v < c_VA[k]);
                e_hs[k]  = !((h >= c_HA[k] + c_HF[k]) && (h < c_HA[k] + c_HF[k] + c_HS[k]));
                e_vs[k]  = !((v >= c_VA[k] + c_VF[k]) && (v < c_VA[k] + c_VF[k] + c_VS[k]));
                e_bn[k]  = act;
                e_rgb[k] = act ? dat : 24'd0;
                pos[k]   = (pos[k] + 1) % (htot(k) * vtot(k));
            end
            check($sformatf("hsync[%0d]", k), 32'(hsync_o[k]), 32'(e_hs[k]));
            check($sformatf("vsync[%0d]", k), 32'(vsync_o[k]), 32'(e_vs[k]));
            check($sformatf("blank_n[%0d]", k), 32'(blank_o[k]), 32'(e_bn[k]));
            check($sformatf("rgb[%0d]", k), {8'd0, r_o[k], g_o[k], b_o[k]}, {8'd0, e_rgb[k]});
        end
    endtask

    logic [26:0] sig_a [200];
    logic [23:0] sig_dat [200];

    initial begin
        int low_cnt, first_low, ticks, guard;
        for (int k = 0; k < 2; k++) begin
            pos[k] = 0; e_hs[k] = 1'b1; e_vs[k] = 1'b1; e_bn[k] = 1'b0; e_rgb[k] = '0;
            fs_count[k] = 0;
        end
        rst = 1'b1; pix_en = 1'b0; pix_data = '0;

        // Reset state, with pix_en asserted to show reset overrides it.
        cycle(1'b1, 1'b1, 24'h123456);
        cycle(1'b1, 1'b0, 24'h0);
        check("reset_hsync", 32'(hsync_o[0]), 32'd1);
        check("reset_vsync", 32'(vsync_o[0]), 32'd1);
        check("reset_blank_n", 32'(blank_o[0]), 32'd0);
        check("reset_rgb", {8'd0, r_o[0], g_o[0], b_o[0]}, 32'd0);

        // First pixel colour, then one full default line with continuous ticks.
        cycle(1'b0, 1'b1, 24'hFF8001);
        check("pix0_r", 32'(r_o[0]), 32'hFF);
        check("pix0_g", 32'(g_o[0]), 32'h80);
        check("pix0_b", 32'(b_o[0]), 32'h01);
        check("pix0_blank_n", 32'(blank_o[0]), 32'd1);
        low_cnt = 0; first_low = -1;
        for (int t = 2; t <= 800; t++) begin
            cycle(1'b0, 1'b1, 24'($urandom));
            if (hsync_o[0] === 1'b0) begin
                low_cnt++;
                if (first_low < 0) first_low = t;
            end
            if (t == 641) begin
                check("h640_blank_n", 32'(blank_o[0]), 32'd0);
                check("h640_rgb", {8'd0, r_o[0], g_o[0], b_o[0]}, 32'd0);
            end
        end
        check("line_hsync_low_ticks", low_cnt, 96);
        check("line_hsync_first_low_tick", first_low, 657);
        check("line_end_h_addr", 32'(h_addr_o[0]), 32'd0);
        check("line_end_v_addr", 32'(v_addr_o[0]), 32'd1);
        check("line_end_req", 32'(req_o[0]), 32'd1);

        // Two reduced-timing frames plus one tick, random pix_en spacing.
        cycle(1'b1, 1'b0, 24'd0);
        fs_count[0] = 0; fs_count[1] = 0; low_cnt = 0; ticks = 0;
        while (ticks < 2 * 608 + 1) begin
            logic en;
            en = ($urandom_range(0, 2) == 0);
            cycle(1'b0, en, 24'($urandom));
            if (en) begin
                ticks++;
                if (vsync_o[1] === 1'b0) low_cnt++;
            end
        end
        check("frame_start_count_small", fs_count[1], 3);
        check("frame_start_count_def", fs_count[0], 1);
        check("frame_vsync_low_ticks", low_cnt, 2 * 2 * 32);

        // Same data per tick with continuous vs 1-in-4 pix_en.
        cycle(1'b1, 1'b0, 24'd0);
        for (int i = 0; i < 200; i++) begin
            sig_dat[i] = 24'($urandom);
            cycle(1'b0, 1'b1, sig_dat[i]);
            sig_a[i] = {hsync_o[1], vsync_o[1], blank_o[1], r_o[1], g_o[1], b_o[1]};
        end
        cycle(1'b1, 1'b0, 24'd0);
        for (int i = 0; i < 200; i++) begin
            for (int j = 0; j < 3; j++) cycle(1'b0, 1'b0, 24'($urandom));
            cycle(1'b0, 1'b1, sig_dat[i]);
            check("slow_vs_fast_tick", {5'd0, hsync_o[1], vsync_o[1], blank_o[1], r_o[1], g_o[1], b_o[1]},
                  {5'd0, sig_a[i]});
        end

        // Mid-frame reset inside both sync pulses of the reduced instance.
        cycle(1'b1, 1'b0, 24'd0);
        guard = 0;
        while (pos[1] != 14 * 32 + 24 && guard < 5000) begin
            cycle(1'b0, 1'($urandom_range(0, 1)), 24'($urandom));
            guard++;
        end
        check("reach_sync_point", 32'(guard < 5000), 32'd1);
        check("pre_rst_hsync", 32'(hsync_o[1]), 32'd0);
        check("pre_rst_vsync", 32'(vsync_o[1]), 32'd0);
        cycle(1'b1, 1'b1, 24'($urandom));
        check("rst_hsync", 32'(hsync_o[1]), 32'd1);
        check("rst_vsync", 32'(vsync_o[1]), 32'd1);
        check("rst_blank_n", 32'(blank_o[1]), 32'd0);
        cycle(1'b0, 1'b0, 24'($urandom));
        check("post_rst_req", 32'(req_o[1]), 32'd1);
        check("post_rst_h_addr", 32'(h_addr_o[1]), 32'd0);
        check("post_rst_v_addr", 32'(v_addr_o[1]), 32'd0);

        // Random soak with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            cycle(1'($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)), 24'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
